// File: rtl/lcd_ctrl_if.sv
// Write port of the LCD controller: the core's store strobe and data word, plus the FIFO-ready flag.
// The master side is the core/LSU and the slave side is lcd_ctrl.
interface lcd_ctrl_if;
    logic        wr_en_i;
    logic [31:0] wr_data_i;
    logic        wr_ready_o;

    modport master (output wr_en_i, output wr_data_i, input wr_ready_o);
    modport slave  (input wr_en_i, input wr_data_i, output wr_ready_o);
endinterface

// File: rtl/lcd_ctrl.sv
// Queues LCD command/data words from the core and replays each one as a timed HD44780 write cycle.
// A single down-counter paces the SETUP / PULSE / HOLD / WAIT phases of every write.
module lcd_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int T_SETUP_CYC = 2,
    parameter int T_EN_CYC    = 12,
    parameter int T_HOLD_CYC  = 2,
    parameter int T_CMD_CYC   = 2000,
    parameter int T_CLR_CYC   = 82000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    lcd_ctrl_if.slave        wr_bus,
    output logic             busy_o,
    output logic [7:0]       lcd_data_o,
    output logic             lcd_rs_o,
    output logic             lcd_rw_o,
    output logic             lcd_en_o,
    output logic             lcd_on_o,
    output logic             lcd_blon_o
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNTW  = AW + 1;
    localparam int T_MAX = max2(max2(max2(T_SETUP_CYC, T_EN_CYC), max2(T_HOLD_CYC, T_CMD_CYC)),
                                T_CLR_CYC);
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int WW    = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    function automatic logic [TW-1:0] load_val(input int t);
        return TW'(t - 1);
    endfunction

    // FIFO entries keep only the bits that reach a pin: {ON, BLON, RS, data}.
    logic [WW-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CNTW-1:0] r_count;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_nxt;

    logic [7:0]      r_data;
    logic            r_rs;
    logic            r_on;
    logic            r_blon;
    logic            r_en;

    logic            w_full;
    logic            w_nonempty;
    logic            w_push;
    logic            w_pop;
    logic            w_long_wait;
    logic [WW-1:0]   w_wr_word;
    logic [WW-1:0]   w_head;
    logic            w_unused_bits;

    assign w_full     = (r_count == CNTW'(FIFO_DEPTH));
    assign w_nonempty = (r_count != '0);
    assign w_push     = wr_bus.wr_en_i && !w_full;
    assign w_wr_word  = {wr_bus.wr_data_i[31], wr_bus.wr_data_i[30], wr_bus.wr_data_i[8:0]};
    assign w_head     = r_mem[r_rptr];
    assign w_unused_bits = ^wr_bus.wr_data_i[29:9];

    // Clear display (0x01) and return home (0x02/0x03) need the long settling time.
    assign w_long_wait = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02) || (r_data == 8'h03));

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_wr_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_en    <= 1'b0;
            r_data  <= '0;
            r_rs    <= 1'b0;
            r_on    <= 1'b0;
            r_blon  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_en    <= (w_state_nxt == S_PULSE);
            if (w_pop) begin
                r_on   <= w_head[10];
                r_blon <= w_head[9];
                r_rs   <= w_head[8];
                r_data <= w_head[7:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = (r_timer != '0) ? (r_timer - TW'(1)) : '0;
        w_pop       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
                if (w_nonempty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_SETUP;
                    w_timer_nxt = load_val(T_SETUP_CYC);
                end
            end
            S_SETUP: begin
                if (r_timer == '0) begin
                    w_state_nxt = S_PULSE;
                    w_timer_nxt = load_val(T_EN_CYC);
                end
            end
            S_PULSE: begin
                if (r_timer == '0) begin
                    w_state_nxt = S_HOLD;
                    w_timer_nxt = load_val(T_HOLD_CYC);
                end
            end
            S_HOLD: begin
                if (r_timer == '0) begin
                    w_state_nxt = S_WAIT;
                    w_timer_nxt = w_long_wait ? load_val(T_CLR_CYC) : load_val(T_CMD_CYC);
                end
            end
            S_WAIT: begin
                // Chain straight into the next write when more words are queued.
                if (r_timer == '0) begin
                    if (w_nonempty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_SETUP;
                        w_timer_nxt = load_val(T_SETUP_CYC);
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_timer_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    assign wr_bus.wr_ready_o = !w_full;
    assign busy_o            = w_nonempty || (r_state != S_IDLE);
    assign lcd_data_o        = r_data;
    assign lcd_rs_o          = r_rs;
    assign lcd_rw_o          = 1'b0;
    assign lcd_en_o          = r_en;
    assign lcd_on_o          = r_on;
    assign lcd_blon_o        = r_blon;

endmodule
